// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA framebuffer path.
// Pixel width, fetch FSM encoding and default fetch timing.
package vga_pkg;

  localparam int PIX_W          = 4;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_FETCH_LAT  = 2;
  localparam int DEF_RST_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSTP  = 2'd1,
    FETCH = 2'd2
  } state_t;

endpackage

// File: rtl/frame_fetch_if.sv
// Pixel handshake between the prefetch stage and scanout.
// master drives valid/data, slave drives ready.
interface frame_fetch_if #(
  parameter int PIX_W = vga_pkg::PIX_W
);

  logic             pix_valid_o;
  logic [PIX_W-1:0] pix_data_o;
  logic             pix_ready_i;

  modport master (
    output pix_valid_o,
    output pix_data_o,
    input  pix_ready_i
  );

  modport slave (
    input  pix_valid_o,
    input  pix_data_o,
    output pix_ready_i
  );

endinterface

// File: rtl/pix_fifo.sv
// Synchronous first-word-fall-through pixel FIFO.
// Head reads as zero while empty.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int PIX_W = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic             valid,
  output logic [PIX_W-1:0] dout,
  output logic [LW-1:0]    level
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (push && rst_n && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = (cnt != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;
  assign level = cnt;

endmodule

// File: rtl/frame_fetch.sv
// Prefetches gray pixels from the RP2040 framebuffer into a FIFO
// so scanout never waits on the strobe-to-sample latency.
module frame_fetch #(
  parameter int PIX_W      = vga_pkg::PIX_W,
  parameter int DEPTH      = vga_pkg::DEF_DEPTH,
  parameter int FETCH_LAT  = vga_pkg::DEF_FETCH_LAT,
  parameter int RST_CYCLES = vga_pkg::DEF_RST_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start_i,
  frame_fetch_if.master          pix,
  output logic                   underrun_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   frame_next_pixel_out,
  output logic                   frame_reset_out,
  input  logic [PIX_W-1:0]       frame_pixel_in
);

  import vga_pkg::*;

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 rst_out_d;
  logic                 strobe_q;
  logic [FETCH_LAT-1:0] pipe_q;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 fifo_valid;
  logic                 underrun_d;
  int                   inflight;
  int                   credit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      RSTP: begin
        if (cnt_q == '0) begin
          state_d = FETCH;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          rst_out_d = 1'b1;
        end
      end
      FETCH: begin
      end
      default: state_d = IDLE;
    endcase
    if (frame_start_i) begin
      state_d   = RSTP;
      cnt_d     = CW'(RST_CYCLES - 1);
      rst_out_d = 1'b1;
    end
  end

  // The strobe just raised counts as in flight, so credit never overshoots.
  always_comb begin
    inflight = int'(strobe_q);
    for (int i = 0; i < FETCH_LAT; i++) begin
      inflight += int'(pipe_q[i]);
    end
    credit = int'(level_o) + inflight;
  end

  assign issue = (state_d == FETCH) && !strobe_q && (credit < DEPTH);
  assign push  = pipe_q[FETCH_LAT-1] && !frame_start_i;
  assign pop   = pix.pix_ready_i && fifo_valid && !frame_start_i;

  assign underrun_d = (state_q == FETCH) && pix.pix_ready_i && !fifo_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      frame_reset_out <= 1'b0;
      underrun_o      <= 1'b0;
      strobe_q        <= 1'b0;
      pipe_q          <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      frame_reset_out <= rst_out_d;
      underrun_o      <= underrun_d;
      if (frame_start_i) begin
        strobe_q <= 1'b0;
        pipe_q   <= '0;
      end else begin
        strobe_q <= issue;
        pipe_q   <= (pipe_q << 1) | FETCH_LAT'(strobe_q);
      end
    end
  end

  assign frame_next_pixel_out = strobe_q;
  assign pix.pix_valid_o      = fifo_valid;

  pix_fifo #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (frame_start_i),
    .push  (push),
    .pop   (pop),
    .din   (frame_pixel_in),
    .valid (fifo_valid),
    .dout  (pix.pix_data_o),
    .level (level_o)
  );

endmodule

// File: tb/tb_frame_fetch.sv
// Bench for frame_fetch: framebuffer model, pixel scoreboard
// and directed frame start / drain / underrun / abort sequences.
module tb_frame_fetch;

  import vga_pkg::*;

  localparam int PW  = 4;
  localparam int DP  = 4;
  localparam int LAT = 2;
  localparam int RC  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start_i;
  logic          underrun_o;
  logic [2:0]    level_o;
  logic          frame_next_pixel_out;
  logic          frame_reset_out;
  logic [PW-1:0] frame_pixel_in = '0;

  frame_fetch_if #(.PIX_W(PW)) pix ();

  frame_fetch #(
    .PIX_W      (PW),
    .DEPTH      (DP),
    .FETCH_LAT  (LAT),
    .RST_CYCLES (RC)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .frame_start_i        (frame_start_i),
    .pix                  (pix),
    .underrun_o           (underrun_o),
    .level_o              (level_o),
    .frame_next_pixel_out (frame_next_pixel_out),
    .frame_reset_out      (frame_reset_out),
    .frame_pixel_in       (frame_pixel_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
               $time);
    end
  endtask

  // model state
  int         hist [0:LAT] = '{default: -1};
  int         fb_ptr = 0;
  int         exp_k = 0;
  int         exp_level = 0;
  bit         exp_ur = 1'b0;
  int         rc = 0;
  bit         started = 1'b0;
  bit         prev_strobe = 1'b0;
  int         pops = 0;
  int         urs = 0;
  logic [3:0] sbq [$];

  always @(negedge clk) begin
    bit         fetch_m;
    bit         exp_valid;
    bit         sample;
    bit         do_pop;
    bit         ur_n;
    int         nxt;
    logic [3:0] e;

    if (rc > 0) rc--;
    fetch_m   = started && (rc == 0);
    exp_valid = (exp_level != 0);

    chk("level", level_o, exp_level);
    chk("valid", pix.pix_valid_o, exp_valid);
    if (!exp_valid) chk("data_zero", pix.pix_data_o, 0);
    chk("reset_out", frame_reset_out, rc > 0);
    chk("underrun", underrun_o, exp_ur);
    if (frame_next_pixel_out) begin
      chk("strobe_gap", prev_strobe, 0);
      chk("strobe_in_fetch", fetch_m, 1);
    end

    // framebuffer: pointer rewinds on reset, advances per strobe
    if (frame_reset_out) fb_ptr = 0;
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    if (frame_next_pixel_out) begin
      fb_ptr++;
      hist[0] = fb_ptr % 16;
      exp_k++;
      e = 4'(exp_k);
      sbq.push_back(e);
    end else begin
      hist[0] = -1;
    end
    sample = (hist[LAT] >= 0);
    frame_pixel_in = sample ? 4'(hist[LAT]) : 4'($urandom_range(0, 15));

    do_pop = exp_valid && pix.pix_ready_i && !frame_start_i && rst_n;
    if (do_pop) begin
      pops++;
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else chk("pixel", pix.pix_data_o, sbq.pop_front());
    end

    ur_n = fetch_m && pix.pix_ready_i && !exp_valid;
    nxt  = exp_level + int'(sample && !frame_start_i) - int'(do_pop);
    prev_strobe = frame_next_pixel_out;

    if (frame_start_i) begin
      sbq.delete();
      exp_k   = 0;
      nxt     = 0;
      started = 1'b1;
      rc      = RC + 1;
      for (int i = 0; i <= LAT; i++) hist[i] = -1;
    end
    if (!rst_n) begin
      sbq.delete();
      exp_k       = 0;
      nxt         = 0;
      started     = 1'b0;
      rc          = 0;
      ur_n        = 1'b0;
      prev_strobe = 1'b0;
      for (int i = 0; i <= LAT; i++) hist[i] = -1;
    end
    exp_level = nxt;
    exp_ur    = ur_n;
    if (exp_ur) urs++;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, pix.pix_valid_o, 0);
    chk({tag, "_data"}, pix.pix_data_o, 0);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_strobe"}, frame_next_pixel_out, 0);
    chk({tag, "_rstout"}, frame_reset_out, 0);
    chk({tag, "_underrun"}, underrun_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    int p0;
    int u0;
    bit found;

    rst_n = 1'b0;
    frame_start_i = 1'b0;
    pix.pix_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    s = 0;
    repeat (50) begin
      @(negedge clk);
      s += int'(frame_next_pixel_out);
    end
    chk("idle_strobes", s, 0);

    // frame start and fill, cycle 0 = start pulse
    @(posedge clk); #1 frame_start_i = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      chk("fill_rstout", frame_reset_out, (c >= 1 && c <= 4));
      chk("fill_strobe", frame_next_pixel_out,
          (c == 5 || c == 7 || c == 9 || c == 11));
      if (c >= 8) begin
        chk("fill_valid", pix.pix_valid_o, 1);
        chk("fill_head", pix.pix_data_o, 1);
      end
      if (c >= 14) chk("fill_level", level_o, 4);
      @(posedge clk); #1 frame_start_i = 1'b0;
    end

    // drain every 2nd cycle
    p0 = pops;
    u0 = urs;
    n  = 0;
    while ((pops - p0) < 64 && n < 400) begin
      pix.pix_ready_i = ~pix.pix_ready_i;
      @(posedge clk); #1;
      n++;
    end
    pix.pix_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("drain_count", (pops - p0) >= 64, 1);
    chk("drain_underruns", urs - u0, 0);

    // continuous ready: underruns expected, order kept
    p0 = pops;
    u0 = urs;
    pix.pix_ready_i = 1'b1;
    repeat (80) @(posedge clk);
    #1 pix.pix_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("underrun_seen", urs > u0, 1);
    chk("underrun_pops", (pops - p0) > 30, 1);

    // abort with data buffered and a request in flight
    found = 1'b0;
    for (n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      found = (level_o >= 1) && frame_next_pixel_out;
    end
    chk("abort_arm", found, 1);
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    @(negedge clk);
    chk("abort_level", level_o, 0);
    chk("abort_valid", pix.pix_valid_o, 0);
    chk("abort_rstout", frame_reset_out, 1);
    found = 1'b0;
    for (n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      found = pix.pix_valid_o;
    end
    chk("restart_valid", found, 1);
    chk("restart_pixel", pix.pix_data_o, 1);

    // sparse ready: pushes and pops coincide near full
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1 pix.pix_ready_i = (i % 3 == 0);
    end

    // reset in the middle of traffic
    pix.pix_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    pix.pix_ready_i = 1'b0;

    // random ready with occasional restarts
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      pix.pix_ready_i = 1'($urandom_range(0, 1));
      frame_start_i   = ($urandom_range(0, 79) == 0);
    end
    pix.pix_ready_i = 1'b0;
    frame_start_i   = 1'b0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/frame_fetch.md
Name: frame_fetch

Overview:
- Pixel prefetch stage between the external RP2040 framebuffer pins and the VGA scanout.
- Drives the framebuffer strobes (frame_next_pixel_out, frame_reset_out) and samples the 4-bit gray pixel bus after a fixed return latency.
- Buffers samples in a small FIFO and hands pixels to the scanout over a valid/ready interface.
- Hides the RP2040 response latency so that scanout never stalls on it.

Parameters:
- PIX_W, 4: pixel width in bits (gray levels).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- FETCH_LAT, 2: cycles from the next-pixel strobe high cycle to the cycle in which frame_pixel_in is sampled; at least 1.
- RST_CYCLES, 4: number of cycles frame_reset_out is held high.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- frame_start_i, in, 1: one-cycle pulse from scanout at start of vertical blank; restarts the frame.
- pix_ready_i, in, 1: scanout consumes a pixel this cycle.
- pix_valid_o, out, 1: FIFO head is valid.
- pix_data_o, out, PIX_W: FIFO head; 0 when pix_valid_o is low.
- underrun_o, out, 1: one-cycle pulse when a pop is requested while in FETCH with the FIFO empty.
- level_o, out, clog2(DEPTH)+1: current FIFO occupancy.
- frame_next_pixel_out, out, 1: advance strobe to the framebuffer; one cycle high per request.
- frame_reset_out, out, 1: rewinds the framebuffer pointer.
- frame_pixel_in, in, PIX_W: pixel bus from the framebuffer.

Behaviour:
- Reset (rst_n low at an edge):
  - State is IDLE. FIFO and in-flight pipe are cleared.
  - All outputs are 0.
- IDLE: waits for frame_start_i, then goes to RSTP.
- RSTP:
  - frame_reset_out is high for exactly RST_CYCLES cycles.
  - A counter counts down from RST_CYCLES-1; at 0, go to FETCH.
  - frame_reset_out is registered.
- FETCH, request issue:
  - Credit = level + inflight.
  - A request is issued when credit < DEPTH and frame_next_pixel_out was low in the previous cycle.
  - The minimum request period is therefore 2 cycles (RP2040 edge detect).
  - frame_next_pixel_out is registered high for that one cycle.
- FETCH, in-flight tracking:
  - A FETCH_LAT-deep shift register tracks requests; inflight is its population count.
  - When a set bit exits the shift register, frame_pixel_in is pushed into the FIFO that cycle.
  - Pixel k is sampled exactly FETCH_LAT cycles after the high cycle of strobe k.
- FIFO:
  - Pop happens when pix_ready_i and pix_valid_o are both high.
  - Push and pop in the same cycle leaves level unchanged, including when full.
  - The credit rule guarantees a push never finds the FIFO full without a pop; overflow is impossible by construction.
  - The read path is first-word-fall-through: a pushed pixel appears on pix_data_o in the next cycle.
  - Pointers wrap modulo DEPTH.
- Underrun:
  - Applies when pix_ready_i is high, the FIFO is empty and the state is FETCH.
  - underrun_o pulses for one cycle; no pop occurs and pix_data_o stays 0.
  - pix_ready_i outside FETCH is ignored with no pulse.
- frame_start_i in any state other than reset:
  - Abort: next cycle the FIFO is cleared, the in-flight pipe is cleared (late samples are discarded), and frame_next_pixel_out is forced low.
  - State goes to RSTP.
  - frame_start_i during RSTP restarts the RST_CYCLES count.
- Simultaneous frame_start_i and a push/pop: the abort wins; the push and pop are dropped.
- Reset mid-operation: identical to power-on reset, within one edge.
- No combinational path from any input to any output except pix_ready_i → nothing. All outputs are registered or derived from registers only.

Decomposition:
- Shared package (vga_pkg): PIX_W, state encoding IDLE/RSTP/FETCH, default FETCH_LAT and RST_CYCLES constants.
- One sub-module, pix_fifo: synchronous FWFT FIFO with parameters DEPTH and PIX_W, ports push/pop/clear, and level output.
- frame_fetch contains the FSM, the strobe generator and the in-flight pipe.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles with frame_start_i=0 → all outputs 0, no strobes for 50 cycles.
2. Frame start, fill (DEPTH=4, FETCH_LAT=2, RST_CYCLES=4, pix_ready_i=0):
   - Stimulus: frame_start_i pulse at cycle 0; the framebuffer model returns 1,2,3,4,...
   - Required: frame_reset_out high for cycles 1–4; strobes on cycles 5, 7, 9, 11.
   - Required: level_o reaches 4 and no further strobes.
   - Required: pix_data_o = 1 with pix_valid_o = 1 from cycle 8.
3. Steady drain: pix_ready_i high every 2nd cycle → pixels 1..64 appear in order with no underrun_o pulse.
4. Underrun: pix_ready_i held high continuously → underrun_o pulses in every cycle the FIFO is empty; every delivered pixel is still in sequence, with no duplicates or skips.
5. Mid-frame abort: frame_start_i while 2 requests are in flight and level=3 → next cycle level_o=0 and pix_valid_o=0; the late samples are never pushed; the RST_CYCLES pulse repeats and the sequence restarts at pixel 1.
6. Simultaneous push/pop at full (level=4): a push and a pop in the same cycle → level stays 4 and output order is preserved.
